// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: decodes all base formats into a sign-extended
// XLEN-bit immediate plus format code, behind a two-entry skid-buffered handshake.
module imm_gen_pipe #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruction,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm_data,
   output logic [2:0]      imm_fmt,
   output logic            illegal
);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // State bits double as {out_valid, skid_valid} so both flags come straight from flops.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL1 = 2'b10,
      FULL2 = 2'b11
   } state_t;

   state_t state, state_next;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            is_shift;
   logic [63:0]     dec_wide;
   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_illegal;

   logic [XLEN-1:0] skid_imm;
   logic [2:0]      skid_fmt;
   logic            skid_illegal;

   logic accept;
   logic drain;
   logic load_out_in;
   logic load_out_skid;
   logic load_skid;

   assign opcode   = instruction[6:0];
   assign funct3   = instruction[14:12];
   assign is_shift = (opcode == OP_IMM || opcode == OP_IMM32) &&
                     (funct3 == 3'b001 || funct3 == 3'b101);

   // Immediates are built 64 bits wide and truncated, so one decoder serves both XLENs.
   always_comb begin
      dec_wide    = 64'd0;
      dec_fmt     = FMT_ILL;
      dec_illegal = 1'b0;
      case (opcode)
         OP_REG, OP_REG32: begin
            dec_wide = 64'd0;
            dec_fmt  = FMT_R;
         end
         OP_LOAD, OP_JALR: begin
            dec_wide = {{52{instruction[31]}}, instruction[31:20]};
            dec_fmt  = FMT_I;
         end
         OP_IMM, OP_IMM32: begin
            dec_fmt = FMT_I;
            if (is_shift) begin
               if (XLEN == 64 && opcode == OP_IMM)
                  dec_wide = {58'd0, instruction[25:20]};
               else
                  dec_wide = {59'd0, instruction[24:20]};
            end else begin
               dec_wide = {{52{instruction[31]}}, instruction[31:20]};
            end
         end
         OP_STORE: begin
            dec_wide = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
            dec_fmt  = FMT_S;
         end
         OP_BRANCH: begin
            dec_wide = {{51{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
            dec_fmt  = FMT_B;
         end
         OP_LUI, OP_AUIPC: begin
            dec_wide = {{32{instruction[31]}}, instruction[31:12], 12'd0};
            dec_fmt  = FMT_U;
         end
         OP_JAL: begin
            dec_wide = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};
            dec_fmt  = FMT_J;
         end
         default: begin
            dec_wide    = 64'd0;
            dec_fmt     = FMT_ILL;
            dec_illegal = 1'b1;
         end
      endcase
   end

   assign dec_imm = dec_wide[XLEN-1:0];

   assign out_valid = state[1];
   assign in_ready  = ~state[0];
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!reset)
         state <= EMPTY;
      else
         state <= state_next;
   end

   // OUT only reloads when empty or draining, which keeps the outputs stable under backpressure.
   always_comb begin
      state_next    = state;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_next  = FULL1;
               load_out_in = 1'b1;
            end
         end
         FULL1: begin
            if (accept && drain) begin
               load_out_in = 1'b1;
            end else if (accept) begin
               state_next = FULL2;
               load_skid  = 1'b1;
            end else if (drain) begin
               state_next = EMPTY;
            end
         end
         FULL2: begin
            if (drain) begin
               state_next    = FULL1;
               load_out_skid = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         imm_data     <= '0;
         imm_fmt      <= 3'd0;
         illegal      <= 1'b0;
         skid_imm     <= '0;
         skid_fmt     <= 3'd0;
         skid_illegal <= 1'b0;
      end else begin
         if (load_out_in) begin
            imm_data <= dec_imm;
            imm_fmt  <= dec_fmt;
            illegal  <= dec_illegal;
         end else if (load_out_skid) begin
            imm_data <= skid_imm;
            imm_fmt  <= skid_fmt;
            illegal  <= skid_illegal;
         end
         if (load_skid) begin
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
         end
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: one XLEN=64 and one XLEN=32 instance share stimulus;
// a negedge monitor pops hand-computed expectations as outputs transfer.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] instruction;

   logic        in_ready64, out_valid64, ill64;
   logic [63:0] imm64;
   logic [2:0]  fmt64;
   logic        in_ready32, out_valid32, ill32;
   logic [31:0] imm32;
   logic [2:0]  fmt32;

   imm_gen_pipe #(.XLEN(64)) dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
      .instruction(instruction), .out_valid(out_valid64), .out_ready(out_ready),
      .imm_data(imm64), .imm_fmt(fmt64), .illegal(ill64)
   );

   imm_gen_pipe #(.XLEN(32)) dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
      .instruction(instruction), .out_valid(out_valid32), .out_ready(out_ready),
      .imm_data(imm32), .imm_fmt(fmt32), .illegal(ill32)
   );

   typedef struct {
      logic [31:0] instr;
      logic [63:0] e64;
      logic [31:0] e32;
      logic [2:0]  fmt;
      logic        ill;
   } vec_t;

   vec_t vecs[16];
   vec_t sbQueue[$];
   int   checkCount = 0;
   int   passCount  = 0;
   int   popCount   = 0;

   function automatic vec_t mk(logic [31:0] instr, logic [63:0] e64, logic [31:0] e32,
                               logic [2:0] fmt, logic ill);
      vec_t v;
      v.instr = instr; v.e64 = e64; v.e32 = e32; v.fmt = fmt; v.ill = ill;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
      checkCount++;
      if (got === want)
         passCount++;
      else
         $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
   endtask

   task automatic applyStimulus(input int idx, output int stalls);
      in_valid    = 1'b1;
      instruction = vecs[idx].instr;
      stalls      = 0;
      while (!in_ready64 && stalls < 50) begin
         @(negedge clk);
         stalls++;
      end
      if (!in_ready64) begin
         checkOutput("accept_timeout", 64'd1, 64'd0);
         in_valid = 1'b0;
      end else begin
         sbQueue.push_back(vecs[idx]);
         @(negedge clk);
      end
   endtask

   // Transfers pop the scoreboard; stalled outputs are compared against the head without popping.
   initial begin
      vec_t e;
      forever begin
         @(negedge clk);
         #1;
         if (reset && out_valid64) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpected_output", 64'd1, 64'd0);
            end else begin
               e = sbQueue[0];
               checkOutput($sformatf("imm64[%h]", e.instr), imm64, e.e64);
               checkOutput($sformatf("fmt_ill64[%h]", e.instr), 64'({fmt64, ill64}), 64'({e.fmt, e.ill}));
               checkOutput($sformatf("imm32[%h]", e.instr), 64'(imm32), 64'(e.e32));
               checkOutput($sformatf("valid_fmt_ill32[%h]", e.instr),
                           64'({out_valid32, fmt32, ill32}), 64'({1'b1, e.fmt, e.ill}));
               if (out_ready) begin
                  void'(sbQueue.pop_front());
                  popCount++;
               end
            end
         end
      end
   end

   initial begin
      int st;
      int totalStalls;
      int popsBefore;
      int waitCycles;

      vecs[0]  = mk(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0);
      vecs[1]  = mk(32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd2, 1'b0);
      vecs[2]  = mk(32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 3'd3, 1'b0);
      vecs[3]  = mk(32'h0010006F, 64'h0000_0000_0000_0800, 32'h0000_0800, 3'd5, 1'b0);
      vecs[4]  = mk(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 3'd4, 1'b0);
      vecs[5]  = mk(32'h03F09093, 64'h0000_0000_0000_003F, 32'h0000_001F, 3'd1, 1'b0);
      vecs[6]  = mk(32'h4010D093, 64'h0000_0000_0000_0001, 32'h0000_0001, 3'd1, 1'b0);
      vecs[7]  = mk(32'h03F0909B, 64'h0000_0000_0000_001F, 32'h0000_001F, 3'd1, 1'b0);
      vecs[8]  = mk(32'h0000007F, 64'h0,                   32'h0,         3'd7, 1'b1);
      vecs[9]  = mk(32'h00000033, 64'h0,                   32'h0,         3'd0, 1'b0);
      vecs[10] = mk(32'h80003083, 64'hFFFF_FFFF_FFFF_F800, 32'hFFFF_F800, 3'd1, 1'b0);
      vecs[11] = mk(32'h7FF08067, 64'h0000_0000_0000_07FF, 32'h0000_07FF, 3'd1, 1'b0);
      vecs[12] = mk(32'h00001017, 64'h0000_0000_0000_1000, 32'h0000_1000, 3'd4, 1'b0);
      vecs[13] = mk(32'hFFF0001B, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0);
      vecs[14] = mk(32'h0000003B, 64'h0,                   32'h0,         3'd0, 1'b0);
      vecs[15] = mk(32'h00000073, 64'h0,                   32'h0,         3'd7, 1'b1);

      reset       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      instruction = 32'd0;
      repeat (2) @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rst_out_valid", 64'(out_valid64), 64'd0);
      checkOutput("rst_in_ready", 64'({in_ready64, in_ready32}), 64'(2'b11));
      checkOutput("rst_imm64", imm64, 64'd0);
      checkOutput("rst_fmt_ill64", 64'({fmt64, ill64}), 64'd0);
      checkOutput("rst_dut32", 64'({out_valid32, imm32, fmt32, ill32}), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] single instruction latency");
      applyStimulus(0, st);
      in_valid = 1'b0;
      checkOutput("latency_valid", 64'(out_valid64), 64'd1);
      @(negedge clk);
      checkOutput("latency_single", 64'(out_valid64), 64'd0);

      $display("[TB] back-to-back format sweep");
      totalStalls = 0;
      popsBefore  = popCount;
      for (int i = 1; i < 16; i++) begin
         applyStimulus(i, st);
         totalStalls += st;
      end
      in_valid = 1'b0;
      checkOutput("sweep_stalls", 64'(totalStalls), 64'd0);
      checkOutput("sweep_tail_valid", 64'(out_valid64), 64'd1);
      @(negedge clk);
      checkOutput("sweep_drained", 64'(out_valid64), 64'd0);
      checkOutput("sweep_pops", 64'(popCount - popsBefore), 64'd15);

      $display("[TB] backpressure");
      popsBefore = popCount;
      out_ready  = 1'b0;
      applyStimulus(1, st);
      checkOutput("bp_ready_after_first", 64'(in_ready64), 64'd1);
      applyStimulus(2, st);
      instruction = vecs[3].instr;
      checkOutput("bp_in_ready_low", 64'(in_ready64), 64'd0);
      checkOutput("bp_hold_first", imm64, vecs[1].e64);
      repeat (3) @(negedge clk);
      checkOutput("bp_still_full", 64'(in_ready64), 64'd0);
      checkOutput("bp_still_first", imm64, vecs[1].e64);
      out_ready = 1'b1;
      applyStimulus(3, st);
      checkOutput("bp_third_stall", 64'(st), 64'd1);
      applyStimulus(4, st);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("bp_pops", 64'(popCount - popsBefore), 64'd4);
      checkOutput("bp_queue_empty", 64'(sbQueue.size()), 64'd0);

      $display("[TB] reset while full");
      out_ready = 1'b0;
      applyStimulus(5, st);
      applyStimulus(6, st);
      checkOutput("rst2_full2", 64'(in_ready64), 64'd0);
      sbQueue.delete();
      reset       = 1'b0;
      in_valid    = 1'b1;
      instruction = vecs[7].instr;
      out_ready   = 1'b1;
      @(negedge clk);
      checkOutput("rst2_out_valid", 64'(out_valid64), 64'd0);
      checkOutput("rst2_in_ready", 64'(in_ready64), 64'd1);
      checkOutput("rst2_imm64", imm64, 64'd0);
      checkOutput("rst2_dut32", 64'({out_valid32, in_ready32, imm32}), 64'({1'b0, 1'b1, 32'd0}));
      reset    = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("idle_ready_toggle", 64'(out_valid64), 64'd0);
      popsBefore = popCount;
      applyStimulus(3, st);
      in_valid = 1'b0;
      checkOutput("rst2_first_valid", 64'(out_valid64), 64'd1);
      @(negedge clk);
      checkOutput("rst2_first_alone", 64'(out_valid64), 64'd0);
      checkOutput("rst2_pops", 64'(popCount - popsBefore), 64'd1);

      waitCycles = 0;
      while (sbQueue.size() != 0 && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("final_queue_empty", 64'(sbQueue.size()), 64'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
